// File: rtl/ceyloniac_instruction_fetch_unit.sv
// Multi-cycle instruction fetch controller: issues memory read requests, hands
// each returned word to the instruction register with a one-cycle strobe, and owns the PC.
module ceyloniac_instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    PC_STEP     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fetch_en,
  input  logic                   stall,
  input  logic                   branch_valid,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic                   mem_read,
  input  logic                   mem_ready,
  input  logic [INSTR_WIDTH-1:0] mem_rdata,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   ir_write,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic [ADDR_WIDTH-1:0]  instr_pc,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  flush_q;
  logic [ADDR_WIDTH-1:0] flush_target_q;
  logic [ADDR_WIDTH-1:0] target_aligned;
  logic [ADDR_WIDTH-1:0] pc_after_write;
  logic                  go_fetch;
  logic                  discard;

  assign target_aligned = branch_target & ~ADDR_WIDTH'(3);
  assign go_fetch       = fetch_en && !stall;
  // A response is thrown away if any branch arrived while it was outstanding,
  // including one arriving on the very edge the data returns.
  assign discard        = flush_q || branch_valid;
  assign pc_after_write = branch_valid ? target_aligned : pc;

  assign mem_read = (state_q == REQ);
  assign busy     = (state_q == REQ);
  assign ir_write = (state_q == WRITE);

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!branch_valid && go_fetch) state_d = REQ;
      REQ:     if (mem_ready) state_d = discard ? IDLE : WRITE;
      WRITE:   state_d = go_fetch ? REQ : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      mem_addr       <= RESET_PC;
      instruction    <= '0;
      instr_pc       <= '0;
      flush_q        <= 1'b0;
      flush_target_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (branch_valid) pc <= target_aligned;
          else if (go_fetch) mem_addr <= pc;
        end
        REQ: begin
          if (mem_ready) begin
            flush_q <= 1'b0;
            if (discard) begin
              pc <= branch_valid ? target_aligned : flush_target_q;
            end else begin
              instruction <= mem_rdata;
              instr_pc    <= mem_addr;
              pc          <= pc + ADDR_WIDTH'(PC_STEP);
            end
          end else if (branch_valid) begin
            flush_q        <= 1'b1;
            flush_target_q <= target_aligned;
          end
        end
        WRITE: begin
          // A branch here overrides the increment applied on delivery.
          pc <= pc_after_write;
          if (go_fetch) mem_addr <= pc_after_write;
        end
        default: ;
      endcase
    end
  end

endmodule
